prince_mprime_serial: RTL and testbench
=======================================

Name: prince_mprime_serial

Overview:
- Iterative, handshaked implementation of the PRINCE M' diffusion layer, M' = diag(M̂0, M̂1, M̂1, M̂0) over four 16-bit chunks.
- Sits directly upstream of the shift-rows permutation (linear_m) in the PRINCE round datapath. Its data_out feeds that block's data_in.
- Computes LANES chunks per cycle through shared M̂ logic to trade area for latency.

Parameters:
- LANES, default 1: 16-bit chunks processed per cycle. Legal values are 1, 2, 4. Latency is 4/LANES cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  data_in holds a block to process.
- in_ready  out  1  block can accept a new input.
- data_in  in  64  state after S-box layer. Bit 63 is the MSB of chunk 0.
- out_valid  out  1  data_out holds a completed M' result.
- out_ready  in  1  downstream accepts data_out.
- data_out  out  64  M'(data_in). Stable while out_valid=1 and out_ready=0.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Chunk k (k = 0..3) is data[63-16k -: 16]. Nibble r (r = 0..3, r=0 is the MSB nibble), bit p (p=0 is the MSB of the nibble).
- M̂0 output: y[r][p] = XOR over c=0..3 with ((r+c) mod 4) != p of x[c][p].
- M̂1 output: same rule with ((r+c+1) mod 4) != p.
- Chunks 0 and 3 use M̂0. Chunks 1 and 2 use M̂1.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: capture data_in into the work register, set cnt=0, go to CALC.
- CALC:
  - Each cycle, transform chunks cnt*LANES .. cnt*LANES+LANES-1 of the work register in place.
  - The matrix for each chunk is selected by its index.
  - After the last group (cnt = 4/LANES-1): go to HOLD.
  - in_ready=0.
- HOLD:
  - out_valid=1, data_out = work register.
  - When out_ready=1: go to IDLE.
  - in_ready=0. No input/output overlap; this keeps the FSM simple.
- Latency from accept to out_valid:
  - 4/LANES cycles.
  - With out_ready tied high, throughput is one block per 4/LANES+2 cycles.
- Reset:
  - Values: state=IDLE, cnt=0, work register=0, in_ready=1, out_valid=0, busy=0, data_out=0.
  - Reset asserted mid-CALC or mid-HOLD aborts the block. No output is produced for it.
- in_valid during CALC or HOLD is ignored. The upstream stage holds it until in_ready.
- out_ready asserted outside HOLD has no effect.
- data_in is sampled only on the accept cycle. Later changes do not affect the result.
- cnt wraps only through the IDLE reload. It never exceeds 4/LANES-1.
- Any LANES value other than 1, 2 or 4 is a fatal elaboration error.

Decomposition:
- Package prince_pkg holds:
  - CHUNK_W=16 and STATE_W=64.
  - Enum mprime_state_t {IDLE, CALC, HOLD}.
  - Function mhat(x[15:0], sel) implementing M̂0/M̂1 per the formula above.
- Sub-module prince_mhat16 wraps one 16-bit M̂ instance with a select input. It is instantiated LANES times.

Test Plan:
1. LANES=1, data_in=0x8000_0000_0000_0000, out_ready=1 -> out_valid on the 4th cycle after accept, data_out=0x0888_0000_0000_0000.
2. data_in=0x0000_8000_0000_0000 -> data_out=0x0000_8880_0000_0000. data_in=all-ones -> data_out=all-ones.
3. Involution check: feed random X, then feed the result back in. The second output must equal X. Run over 1000 vectors for LANES=1, 2, 4 against the reference model.
4. Back-pressure: out_ready=0 for 5 cycles in HOLD -> data_out stable, in_ready=0, a new in_valid is not accepted. When out_ready=1, IDLE follows on the next cycle.
5. Reset asserted during CALC cycle 2 -> next cycle shows out_valid=0, in_ready=1, data_out=0. No spurious output.
6. LANES=4 -> latency of 1 cycle. data_in toggled after accept does not change the result.

Source files
------------

// File: rtl/prince_pkg.sv
// Shared definitions for the PRINCE M' diffusion layer.
// Contents: chunk/state widths, the controller state enum, and mhat(),
// the 16-bit M-hat0 / M-hat1 transform selected by a single bit.
package prince_pkg;

  localparam int CHUNK_W = 16;
  localparam int STATE_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } mprime_state_t;

  // Nibble r (0 = MSB nibble), bit p (0 = MSB of nibble) sits at bit 15-4r-p.
  // Output bit [r][p] is the XOR of input bits [c][p] over every c whose
  // rotated position (r+c+sel) mod 4 differs from p.
  function automatic logic [CHUNK_W-1:0] mhat(input logic [CHUNK_W-1:0] x,
                                               input logic               sel);
    logic [CHUNK_W-1:0] y;
    int                 sh;
    y  = '0;
    sh = sel ? 1 : 0;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 4; p++) begin
        for (int c = 0; c < 4; c++) begin
          if (((r + c + sh) % 4) != p) begin
            y[15-4*r-p] = y[15-4*r-p] ^ x[15-4*c-p];
          end
        end
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/prince_mhat16.sv
// One 16-bit M-hat transform lane.
// Ports: i_x   - 16-bit input chunk
//        i_sel - 0 selects M-hat0, 1 selects M-hat1
//        o_y   - transformed chunk (purely combinational)
module prince_mhat16
  import prince_pkg::*;
(
  input  logic [CHUNK_W-1:0] i_x,
  input  logic               i_sel,
  output logic [CHUNK_W-1:0] o_y
);

  assign o_y = mhat(i_x, i_sel);

endmodule

// File: rtl/prince_mprime_serial.sv
// Iterative PRINCE M' layer: diag(M0, M1, M1, M0) over four 16-bit chunks,
// LANES chunks per cycle through shared M-hat lanes.
// Ports: clk, rst (sync, active high)
//        in_valid/in_ready/data_in     - input handshake, block sampled on accept
//        out_valid/out_ready/data_out  - result handshake, data held until taken
//        busy                          - controller not in IDLE
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// CALC  | transforming one group of LANES chunks per cycle
// HOLD  | result presented until out_ready
module prince_mprime_serial
  import prince_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] data_out,
  output logic               busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $fatal(1, "prince_mprime_serial: LANES must be 1, 2 or 4");
  end

  localparam int         NGROUPS  = 4 / LANES;
  localparam logic [1:0] LAST_CNT = 2'(NGROUPS - 1);

  mprime_state_t r_state, w_state_nxt;
  logic [1:0]    r_cnt;
  // Element 0 is the MSB chunk, so chunk index k maps directly to r_work[k].
  logic [0:3][CHUNK_W-1:0] r_work, w_work_calc;
  logic w_load, w_step, w_last;

  logic [1:0]         w_idx      [LANES];
  logic [CHUNK_W-1:0] w_lane_in  [LANES];
  logic [CHUNK_W-1:0] w_lane_out [LANES];
  logic               w_lane_sel [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_idx[l]      = 2'(int'(r_cnt) * LANES + l);
      w_lane_in[l]  = r_work[w_idx[l]];
      // Middle chunks use M-hat1, outer chunks M-hat0.
      w_lane_sel[l] = (w_idx[l] == 2'd1) || (w_idx[l] == 2'd2);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    prince_mhat16 u_mhat (
      .i_x   (w_lane_in[g]),
      .i_sel (w_lane_sel[g]),
      .o_y   (w_lane_out[g])
    );
  end

  always_comb begin
    w_work_calc = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_work_calc[w_idx[l]] = w_lane_out[l];
    end
  end

  assign w_last = (r_cnt == LAST_CNT);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_work  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_work <= data_in;
        r_cnt  <= 2'd0;
      end else if (w_step) begin
        r_work <= w_work_calc;
        // Hold at the last group; only the IDLE reload rewinds the counter.
        if (!w_last) r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  assign data_out = r_work;

endmodule

// File: tb/tb_prince_mprime_serial.sv
module tb_prince_mprime_serial;

  logic             clk;
  logic             rst;
  logic [2:0]       in_valid;
  logic [2:0]       in_ready;
  logic [2:0][63:0] data_in;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic [2:0][63:0] data_out;
  logic [2:0]       busy;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  prince_mprime_serial #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .data_out(data_out[0]), .busy(busy[0]));

  prince_mprime_serial #(.LANES(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .data_out(data_out[1]), .busy(busy[1]));

  prince_mprime_serial #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data_in(data_in[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .data_out(data_out[2]), .busy(busy[2]));

  function automatic int lanes_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  // Each output bit is the column parity of its bit position within the chunk,
  // with the one excluded input nibble c = (p - r - m) mod 4 removed again.
  function automatic logic [63:0] ref_mprime(input logic [63:0] x);
    logic [63:0] y;
    logic [15:0] ch;
    logic        par;
    int          m, excl;
    y = '0;
    for (int k = 0; k < 4; k++) begin
      ch = x[63-16*k -: 16];
      m  = (k == 1 || k == 2) ? 1 : 0;
      for (int p = 0; p < 4; p++) begin
        par = 1'b0;
        for (int c = 0; c < 4; c++) par = par ^ ch[15-4*c-p];
        for (int r = 0; r < 4; r++) begin
          excl = (p - r - m + 8) % 4;
          y[63-16*k-4*r-p] = par ^ ch[15-4*excl-p];
        end
      end
    end
    return y;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Drives one block from an idle DUT with out_ready high, scrambles data_in
  // right after the accept edge, returns the result and accept-to-valid cycles.
  task automatic run_block(input int k, input logic [63:0] din,
                           output logic [63:0] dout, output int lat);
    in_valid[k] = 1'b1;
    data_in[k]  = din;
    @(negedge clk);
    in_valid[k] = 1'b0;
    data_in[k]  = rand64();
    lat = 0;
    while (!out_valid[k] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    dout = data_out[k];
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
          data_out[k] !== 64'h0) begin
        errors++;
        $display("FAIL reset_state lanes=%0d got rdy=%b ov=%b busy=%b do=%h want 1 0 0 0",
                 lanes_of(k), in_ready[k], out_valid[k], busy[k], data_out[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_known_vectors();
    logic [63:0] vin [3];
    logic [63:0] vexp[3];
    logic [63:0] dout;
    int          lat;
    vin[0] = 64'h8000_0000_0000_0000; vexp[0] = 64'h0888_0000_0000_0000;
    vin[1] = 64'h0000_8000_0000_0000; vexp[1] = 64'h0000_8880_0000_0000;
    vin[2] = 64'hFFFF_FFFF_FFFF_FFFF; vexp[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      run_block(0, vin[i], dout, lat);
      checks++;
      if (dout !== vexp[i]) begin
        errors++;
        $display("FAIL known_vec%0d got %h want %h", i, dout, vexp[i]);
      end
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL known_lat%0d got %0d want 4", i, lat);
      end
    end
  endtask

  task automatic test_involution();
    logic [63:0] x, y, z;
    int          lat1, lat2;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        x = rand64();
        run_block(k, x, y, lat1);
        run_block(k, y, z, lat2);
        checks++;
        if (y !== ref_mprime(x)) begin
          errors++;
          $display("FAIL invol_model lanes=%0d x=%h got %h want %h",
                   lanes_of(k), x, y, ref_mprime(x));
        end
        checks++;
        if (z !== x) begin
          errors++;
          $display("FAIL invol_back lanes=%0d got %h want %h", lanes_of(k), z, x);
        end
        checks++;
        if (lat1 !== 4 / lanes_of(k) || lat2 !== 4 / lanes_of(k)) begin
          errors++;
          $display("FAIL invol_lat lanes=%0d got %0d/%0d want %0d",
                   lanes_of(k), lat1, lat2, 4 / lanes_of(k));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int          pos[$];
    logic [63:0] x;
    int          gap_bad, data_bad, guard;
    for (int k = 0; k < 3; k++) begin
      pos.delete();
      gap_bad = 0; data_bad = 0;
      x = rand64();
      in_valid[k] = 1'b1;
      data_in[k]  = x;
      for (int t = 0; t < 30; t++) begin
        @(negedge clk);
        if (out_valid[k]) begin
          pos.push_back(t);
          if (data_out[k] !== ref_mprime(x)) data_bad++;
        end
      end
      in_valid[k] = 1'b0;
      guard = 0;
      while (busy[k] && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      for (int i = 1; i < pos.size(); i++)
        if (pos[i] - pos[i-1] != 4 / lanes_of(k) + 2) gap_bad++;
      checks++;
      if (pos.size() < 3 || gap_bad != 0) begin
        errors++;
        $display("FAIL b2b_rate lanes=%0d got pulses=%0d bad_gaps=%0d want >=3 pulses spaced %0d",
                 lanes_of(k), pos.size(), gap_bad, 4 / lanes_of(k) + 2);
      end
      checks++;
      if (data_bad != 0) begin
        errors++;
        $display("FAIL b2b_data lanes=%0d got %0d wrong results want 0", lanes_of(k), data_bad);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] x, held;
    int          guard;
    x = rand64();
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    data_in[0]   = x;
    @(negedge clk);
    in_valid[0] = 1'b0;
    guard = 0;
    while (!out_valid[0] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    held = data_out[0];
    checks++;
    if (held !== ref_mprime(x)) begin
      errors++;
      $display("FAIL bp_result got %h want %h", held, ref_mprime(x));
    end
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      data_in[0]  = ~x;
      @(negedge clk);
      checks++;
      if (data_out[0] !== held || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got do=%h rdy=%b ov=%b want do=%h rdy=0 ov=1",
                 i, data_out[0], in_ready[0], out_valid[0], held);
      end
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got busy=%b ov=%b rdy=%b want 0 0 1",
               busy[0], out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_reset_mid();
    int spurious;
    in_valid[0] = 1'b1;
    data_in[0]  = rand64() | 64'h1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || data_out[0] !== 64'h0 ||
        busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got ov=%b rdy=%b do=%h busy=%b want 0 1 0 0",
               out_valid[0], in_ready[0], data_out[0], busy[0]);
    end
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid[0]) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL rst_spurious got %0d out_valid cycles want 0", spurious);
    end
  endtask

  task automatic test_late_change();
    logic [63:0] x;
    x = rand64();
    in_valid[2] = 1'b1;
    data_in[2]  = x;
    @(negedge clk);
    in_valid[2] = 1'b0;
    data_in[2]  = ~x;
    @(negedge clk);
    checks++;
    if (out_valid[2] !== 1'b1 || data_out[2] !== ref_mprime(x)) begin
      errors++;
      $display("FAIL late_change got ov=%b do=%h want ov=1 do=%h",
               out_valid[2], data_out[2], ref_mprime(x));
    end
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '1;
    data_in   = '0;
    test_reset();
    test_known_vectors();
    test_involution();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_late_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
